// File: rtl/alu_share_arbiter_if.sv
// Connection bundle for the ALU share arbiter: two requester issue ports, the
// shared registered ALU, and the two buffered response ports.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req0_pc;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] req1_pc;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_pc;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp0_zero;
    logic              rsp0_err;

    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              rsp1_zero;
    logic              rsp1_err;

    // The arbiter side: takes requests and ALU results, drives ALU and responses.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_pc,
        input  req1_valid, req1_op, req1_a, req1_b, req1_pc,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_pc,
        input  alu_result, alu_zero,
        output rsp0_valid, rsp0_data, rsp0_zero, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_zero, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_pc,
        output req1_valid, req1_op, req1_a, req1_b, req1_pc,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_pc,
        output alu_result, alu_zero,
        input  rsp0_valid, rsp0_data, rsp0_zero, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_zero, rsp1_err,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one registered 1-cycle ALU between two requesters, each with one op in
// flight, a buffered response, and local rejection of illegal op codes.
module alu_share_arbiter #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 6,
    parameter int MAX_OP    = 19,
    parameter int FIXED_PRI = 0,
    parameter int NOP_OP    = 63
) (
    input logic            clock,
    input logic            reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [OP_W-1:0] MaxOp = OP_W'(MAX_OP);
    localparam logic [OP_W-1:0] NopOp = OP_W'(NOP_OP);

    typedef enum logic [1:0] {
        IDLE,
        ISSUED,
        RSP
    } portState_t;

    portState_t        state_q [2];
    logic [1:0]        rspValid_q;
    logic [1:0]        rspZero_q;
    logic [1:0]        rspErr_q;
    logic [DATA_W-1:0] rspData_q [2];
    logic              rrPtr_q;
    logic              rrPtr_d;

    logic [1:0]        reqValid;
    logic [1:0]        rspReady;
    logic [OP_W-1:0]   reqOp [2];
    logic [DATA_W-1:0] reqA [2];
    logic [DATA_W-1:0] reqB [2];
    logic [DATA_W-1:0] reqPc [2];
    logic [1:0]        legal;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              winner;
    logic              issueLegal;
    logic [OP_W-1:0]   aluOp;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluPc;

    assign reqValid = {bus.req1_valid, bus.req0_valid};
    assign rspReady = {bus.rsp1_ready, bus.rsp0_ready};
    assign reqOp[0] = bus.req0_op;
    assign reqOp[1] = bus.req1_op;
    assign reqA[0]  = bus.req0_a;
    assign reqA[1]  = bus.req1_a;
    assign reqB[0]  = bus.req0_b;
    assign reqB[1]  = bus.req1_b;
    assign reqPc[0] = bus.req0_pc;
    assign reqPc[1] = bus.req1_pc;

    assign legal[0] = (reqOp[0] <= MaxOp);
    assign legal[1] = (reqOp[1] <= MaxOp);

    // rrPtr_q names the favoured port when both compete; ready is forced low
    // while reset is held so nothing can be accepted during an async reset.
    always_comb begin
        eligible[0] = reqValid[0] && (state_q[0] == IDLE);
        eligible[1] = reqValid[1] && (state_q[1] == IDLE);
        grant       = 2'b00;
        if (!reset) begin
            if (eligible == 2'b11) begin
                grant = ((FIXED_PRI != 0) || !rrPtr_q) ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign winner         = grant[1];
    assign issueLegal     = (|grant) && legal[winner];
    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // After a handshake the pointer favours whichever port did not just win.
    assign rrPtr_d = (|grant) ? grant[0] : rrPtr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rrPtr_q <= 1'b0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        aluOp = NopOp;
        aluA  = '0;
        aluB  = '0;
        aluPc = '0;
        if (issueLegal) begin
            aluOp = reqOp[winner];
            aluA  = reqA[winner];
            aluB  = reqB[winner];
            aluPc = reqPc[winner];
        end
    end

    assign bus.alu_op = aluOp;
    assign bus.alu_a  = aluA;
    assign bus.alu_b  = aluB;
    assign bus.alu_pc = aluPc;

    // Only one port can be ISSUED in a given cycle, so the shared ALU result is
    // always captured by the port that issued in the previous cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n]    <= IDLE;
                rspValid_q[n] <= 1'b0;
                rspZero_q[n]  <= 1'b0;
                rspErr_q[n]   <= 1'b0;
                rspData_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                case (state_q[n])
                    IDLE: begin
                        if (grant[n]) begin
                            if (legal[n]) begin
                                state_q[n] <= ISSUED;
                            end else begin
                                state_q[n]    <= RSP;
                                rspValid_q[n] <= 1'b1;
                                rspData_q[n]  <= '0;
                                rspZero_q[n]  <= 1'b0;
                                rspErr_q[n]   <= 1'b1;
                            end
                        end
                    end
                    ISSUED: begin
                        state_q[n]    <= RSP;
                        rspValid_q[n] <= 1'b1;
                        rspData_q[n]  <= bus.alu_result;
                        rspZero_q[n]  <= bus.alu_zero;
                        rspErr_q[n]   <= 1'b0;
                    end
                    RSP: begin
                        if (rspReady[n]) begin
                            state_q[n]    <= IDLE;
                            rspValid_q[n] <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[n] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rsp0_valid = rspValid_q[0];
    assign bus.rsp0_data  = rspData_q[0];
    assign bus.rsp0_zero  = rspZero_q[0];
    assign bus.rsp0_err   = rspErr_q[0];
    assign bus.rsp1_valid = rspValid_q[1];
    assign bus.rsp1_data  = rspData_q[1];
    assign bus.rsp1_zero  = rspZero_q[1];
    assign bus.rsp1_err   = rspErr_q[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin and one fixed-priority
// instance, each driving a small behavioural registered ALU.
module tb_alu_share_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] rrAluResult = '0;
    logic        rrAluZero = 1'b0;
    logic [31:0] fxAluResult = '0;
    logic        fxAluZero = 1'b0;

    alu_share_arbiter_if #(.DATA_W(32), .OP_W(6)) rrBus ();
    alu_share_arbiter_if #(.DATA_W(32), .OP_W(6)) fxBus ();

    alu_share_arbiter #(.DATA_W(32), .OP_W(6), .MAX_OP(19), .FIXED_PRI(0), .NOP_OP(63)) dutRr (
        .clock(clock),
        .reset(reset),
        .bus  (rrBus.slave)
    );

    alu_share_arbiter #(.DATA_W(32), .OP_W(6), .MAX_OP(19), .FIXED_PRI(1), .NOP_OP(63)) dutFx (
        .clock(clock),
        .reset(reset),
        .bus  (fxBus.slave)
    );

    always #5 clock = ~clock;

    // Stand-in ALU: 0 add, 1 sub, 2 xor, 19 pc+b; the idle op leaves it holding.
    function automatic logic [31:0] aluCalc(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a ^ b;
            6'd19:   return pc + b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (rrBus.alu_op != 6'd63) begin
            rrAluResult <= aluCalc(rrBus.alu_op, rrBus.alu_a, rrBus.alu_b, rrBus.alu_pc);
            rrAluZero   <= (aluCalc(rrBus.alu_op, rrBus.alu_a, rrBus.alu_b, rrBus.alu_pc) == 32'd0);
        end
        if (fxBus.alu_op != 6'd63) begin
            fxAluResult <= aluCalc(fxBus.alu_op, fxBus.alu_a, fxBus.alu_b, fxBus.alu_pc);
            fxAluZero   <= (aluCalc(fxBus.alu_op, fxBus.alu_a, fxBus.alu_b, fxBus.alu_pc) == 32'd0);
        end
    end

    assign rrBus.alu_result = rrAluResult;
    assign rrBus.alu_zero   = rrAluZero;
    assign fxBus.alu_result = fxAluResult;
    assign fxBus.alu_zero   = fxAluZero;

    task automatic applyStimulus();
        rrBus.req0_valid = 1'b0; rrBus.req0_op = '0; rrBus.req0_a = '0; rrBus.req0_b = '0; rrBus.req0_pc = '0;
        rrBus.req1_valid = 1'b0; rrBus.req1_op = '0; rrBus.req1_a = '0; rrBus.req1_b = '0; rrBus.req1_pc = '0;
        rrBus.rsp0_ready = 1'b0; rrBus.rsp1_ready = 1'b0;
        fxBus.req0_valid = 1'b0; fxBus.req0_op = '0; fxBus.req0_a = '0; fxBus.req0_b = '0; fxBus.req0_pc = '0;
        fxBus.req1_valid = 1'b0; fxBus.req1_op = '0; fxBus.req1_a = '0; fxBus.req1_b = '0; fxBus.req1_pc = '0;
        fxBus.rsp0_ready = 1'b0; fxBus.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus();
        rrBus.req0_valid = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (rrBus.req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req0_ready got=%0h exp=0", rrBus.req0_ready); end
        checks++; if (rrBus.alu_op !== 6'd63) begin failures++; $display("[TB] FAIL reset_alu_op got=%0d exp=63", rrBus.alu_op); end
        checks++; if (rrBus.alu_a !== 32'd0) begin failures++; $display("[TB] FAIL reset_alu_a got=%0h exp=0", rrBus.alu_a); end
        checks++; if ({rrBus.rsp0_valid, rrBus.rsp1_valid, rrBus.rsp0_err, rrBus.rsp1_zero} !== 4'b0) begin
            failures++; $display("[TB] FAIL reset_rsp_flags got=%b exp=0000", {rrBus.rsp0_valid, rrBus.rsp1_valid, rrBus.rsp0_err, rrBus.rsp1_zero});
        end
        checks++; if (rrBus.rsp0_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_rsp0_data got=%0h exp=0", rrBus.rsp0_data); end
        rrBus.req0_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op();
        rrBus.req0_valid = 1'b1; rrBus.req0_op = 6'd0; rrBus.req0_a = 32'd5; rrBus.req0_b = 32'd3;
        #1;
        checks++; if (rrBus.req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_issue_ready got=%0h exp=1", rrBus.req0_ready); end
        @(negedge clock);
        rrBus.req0_valid = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        #1;
        checks++; if (rrBus.rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_rsp0_valid got=%0h exp=0", rrBus.rsp0_valid); end
        @(negedge clock);
    endtask

    task automatic test_single_op();
        rrBus.req0_valid = 1'b1; rrBus.req0_op = 6'd0; rrBus.req0_a = 32'd5; rrBus.req0_b = 32'd3;
        #1;
        checks++; if (rrBus.req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%0h exp=1", rrBus.req0_ready); end
        checks++; if ({rrBus.alu_op, rrBus.alu_a, rrBus.alu_b} !== {6'd0, 32'd5, 32'd3}) begin
            failures++; $display("[TB] FAIL single_alu_drive got=%0d/%0h/%0h exp=0/5/3", rrBus.alu_op, rrBus.alu_a, rrBus.alu_b);
        end
        @(negedge clock);
        rrBus.req0_valid = 1'b0;
        #1;
        checks++; if (rrBus.rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid got=%0h exp=0", rrBus.rsp0_valid); end
        checks++; if (rrBus.alu_op !== 6'd63) begin failures++; $display("[TB] FAIL single_idle_alu_op got=%0d exp=63", rrBus.alu_op); end
        @(negedge clock);
        rrBus.req0_valid = 1'b1; rrBus.req0_op = 6'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if ({rrBus.rsp0_valid, rrBus.rsp0_zero, rrBus.rsp0_err} !== 3'b100) begin
                failures++; $display("[TB] FAIL single_rsp_flags cyc=%0d got=%b exp=100", c, {rrBus.rsp0_valid, rrBus.rsp0_zero, rrBus.rsp0_err});
            end
            checks++; if (rrBus.rsp0_data !== 32'd8) begin failures++; $display("[TB] FAIL single_rsp_data cyc=%0d got=%0h exp=8", c, rrBus.rsp0_data); end
            checks++; if (rrBus.req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_ready cyc=%0d got=%0h exp=0", c, rrBus.req0_ready); end
            if (c == 3) begin
                rrBus.rsp0_ready = 1'b1;
                rrBus.req0_valid = 1'b0;
            end
            @(negedge clock);
        end
        #1;
        checks++; if (rrBus.rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_consumed got=%0h exp=0", rrBus.rsp0_valid); end
        rrBus.rsp0_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_contention_rr();
        logic [5:0] expR0 = 6'b001001;
        logic [5:0] expR1 = 6'b010010;
        logic [5:0] expV0 = 6'b100100;
        logic [5:0] expV1 = 6'b001000;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        rrBus.rsp0_ready = 1'b1; rrBus.rsp1_ready = 1'b1;
        rrBus.req0_valid = 1'b1; rrBus.req0_op = 6'd1; rrBus.req0_a = 32'd7; rrBus.req0_b = 32'd7;
        rrBus.req1_valid = 1'b1; rrBus.req1_op = 6'd1; rrBus.req1_a = 32'd7; rrBus.req1_b = 32'd7;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if ({rrBus.req0_ready, rrBus.req1_ready} !== {expR0[c], expR1[c]}) begin
                failures++; $display("[TB] FAIL rr_grant cyc=%0d got=%b exp=%b", c, {rrBus.req0_ready, rrBus.req1_ready}, {expR0[c], expR1[c]});
            end
            checks++; if ({rrBus.rsp0_valid, rrBus.rsp1_valid} !== {expV0[c], expV1[c]}) begin
                failures++; $display("[TB] FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", c, {rrBus.rsp0_valid, rrBus.rsp1_valid}, {expV0[c], expV1[c]});
            end
            if (expV0[c]) begin
                checks++; if ({rrBus.rsp0_data, rrBus.rsp0_zero} !== {32'd0, 1'b1}) begin
                    failures++; $display("[TB] FAIL rr_rsp0_result cyc=%0d got=%0h/%0h exp=0/1", c, rrBus.rsp0_data, rrBus.rsp0_zero);
                end
            end
            if (expV1[c]) begin
                checks++; if ({rrBus.rsp1_data, rrBus.rsp1_zero} !== {32'd0, 1'b1}) begin
                    failures++; $display("[TB] FAIL rr_rsp1_result cyc=%0d got=%0h/%0h exp=0/1", c, rrBus.rsp1_data, rrBus.rsp1_zero);
                end
            end
            @(negedge clock);
        end
        rrBus.req0_valid = 1'b0; rrBus.req1_valid = 1'b0;
        repeat (3) @(negedge clock);
        rrBus.rsp0_ready = 1'b0; rrBus.rsp1_ready = 1'b0;
    endtask

    task automatic test_illegal_op();
        logic [5:0] badOps [2] = '{6'd25, 6'd20};
        for (int k = 0; k < 2; k++) begin
            rrBus.req1_valid = 1'b1; rrBus.req1_op = badOps[k]; rrBus.req1_a = 32'h11; rrBus.req1_b = 32'h22;
            #1;
            checks++; if (rrBus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL illegal_ready op=%0d got=%0h exp=1", badOps[k], rrBus.req1_ready); end
            checks++; if ({rrBus.alu_op, rrBus.alu_a} !== {6'd63, 32'd0}) begin
                failures++; $display("[TB] FAIL illegal_alu_blocked op=%0d got=%0d/%0h exp=63/0", badOps[k], rrBus.alu_op, rrBus.alu_a);
            end
            @(negedge clock);
            rrBus.req1_valid = 1'b0;
            #1;
            checks++; if ({rrBus.rsp1_valid, rrBus.rsp1_err, rrBus.rsp1_zero} !== 3'b110) begin
                failures++; $display("[TB] FAIL illegal_rsp_flags op=%0d got=%b exp=110", badOps[k], {rrBus.rsp1_valid, rrBus.rsp1_err, rrBus.rsp1_zero});
            end
            checks++; if (rrBus.rsp1_data !== 32'd0) begin failures++; $display("[TB] FAIL illegal_rsp_data op=%0d got=%0h exp=0", badOps[k], rrBus.rsp1_data); end
            rrBus.rsp1_ready = 1'b1;
            @(negedge clock);
            #1;
            checks++; if (rrBus.rsp1_valid !== 1'b0) begin failures++; $display("[TB] FAIL illegal_consumed op=%0d got=%0h exp=0", badOps[k], rrBus.rsp1_valid); end
            rrBus.rsp1_ready = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        rrBus.req1_valid = 1'b1; rrBus.req1_op = 6'd19; rrBus.req1_a = 32'h55; rrBus.req1_b = 32'h20; rrBus.req1_pc = 32'h100;
        #1;
        checks++; if (rrBus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready1 got=%0h exp=1", rrBus.req1_ready); end
        checks++; if ({rrBus.alu_op, rrBus.alu_b, rrBus.alu_pc} !== {6'd19, 32'h20, 32'h100}) begin
            failures++; $display("[TB] FAIL b2b_alu_pc_drive got=%0d/%0h/%0h exp=19/20/100", rrBus.alu_op, rrBus.alu_b, rrBus.alu_pc);
        end
        @(negedge clock);
        rrBus.req1_valid = 1'b0;
        rrBus.req0_valid = 1'b1; rrBus.req0_op = 6'd2; rrBus.req0_a = 32'hF0; rrBus.req0_b = 32'hFF; rrBus.req0_pc = 32'd0;
        #1;
        checks++; if ({rrBus.req0_ready, rrBus.alu_op, rrBus.alu_a} !== {1'b1, 6'd2, 32'hF0}) begin
            failures++; $display("[TB] FAIL b2b_port0_issue got=%0h/%0d/%0h exp=1/2/f0", rrBus.req0_ready, rrBus.alu_op, rrBus.alu_a);
        end
        @(negedge clock);
        rrBus.req0_valid = 1'b0;
        #1;
        checks++; if ({rrBus.rsp1_valid, rrBus.rsp1_data} !== {1'b1, 32'h120}) begin
            failures++; $display("[TB] FAIL b2b_rsp1 got=%0h/%0h exp=1/120", rrBus.rsp1_valid, rrBus.rsp1_data);
        end
        checks++; if (rrBus.rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_rsp0_early got=%0h exp=0", rrBus.rsp0_valid); end
        @(negedge clock);
        #1;
        checks++; if ({rrBus.rsp0_valid, rrBus.rsp0_data, rrBus.rsp0_zero} !== {1'b1, 32'h0F, 1'b0}) begin
            failures++; $display("[TB] FAIL b2b_rsp0 got=%0h/%0h/%0h exp=1/f/0", rrBus.rsp0_valid, rrBus.rsp0_data, rrBus.rsp0_zero);
        end
        checks++; if ({rrBus.rsp1_valid, rrBus.rsp1_data} !== {1'b1, 32'h120}) begin
            failures++; $display("[TB] FAIL b2b_rsp1_held got=%0h/%0h exp=1/120", rrBus.rsp1_valid, rrBus.rsp1_data);
        end
        rrBus.rsp0_ready = 1'b1; rrBus.rsp1_ready = 1'b1;
        @(negedge clock);
        #1;
        checks++; if ({rrBus.rsp0_valid, rrBus.rsp1_valid} !== 2'b00) begin
            failures++; $display("[TB] FAIL b2b_drained got=%b exp=00", {rrBus.rsp0_valid, rrBus.rsp1_valid});
        end
        rrBus.rsp0_ready = 1'b0; rrBus.rsp1_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fixed_pri();
        fxBus.rsp0_ready = 1'b1; fxBus.rsp1_ready = 1'b1;
        fxBus.req0_op = 6'd0; fxBus.req0_a = 32'd1; fxBus.req0_b = 32'd2;
        fxBus.req1_op = 6'd0; fxBus.req1_a = 32'd1; fxBus.req1_b = 32'd2;
        for (int t = 0; t < 3; t++) begin
            fxBus.req0_valid = 1'b1; fxBus.req1_valid = 1'b1;
            #1;
            checks++; if ({fxBus.req0_ready, fxBus.req1_ready} !== 2'b10) begin
                failures++; $display("[TB] FAIL fixed_both_idle trial=%0d got=%b exp=10", t, {fxBus.req0_ready, fxBus.req1_ready});
            end
            @(negedge clock);
            fxBus.req0_valid = 1'b0;
            fxBus.req1_valid = (t == 0);
            #1;
            if (t == 0) begin
                checks++; if (fxBus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL fixed_port1_when_busy got=%0h exp=1", fxBus.req1_ready); end
            end
            @(negedge clock);
            fxBus.req1_valid = 1'b0;
            #1;
            checks++; if ({fxBus.rsp0_valid, fxBus.rsp0_data} !== {1'b1, 32'd3}) begin
                failures++; $display("[TB] FAIL fixed_rsp0 trial=%0d got=%0h/%0h exp=1/3", t, fxBus.rsp0_valid, fxBus.rsp0_data);
            end
            repeat (3) @(negedge clock);
        end
        fxBus.rsp0_ready = 1'b0; fxBus.rsp1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_single_op();
        test_contention_rr();
        test_illegal_op();
        test_back_to_back();
        test_fixed_pri();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
